// File: rtl/ip_sequencer_pkg.sv
// Shared definitions for the instruction-pointer sequencer: FSM state
// encodings, the default interrupt vector and the IP successor helper.
package ip_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h0000_0100;

  // Successor address, wrapping modulo 2^32.
  function automatic logic [31:0] ip_plus_one(input logic [31:0] a);
    return a + 32'd1;
  endfunction

endpackage

// File: rtl/ip_sequencer_if.sv
// Instruction-memory and instruction-issue handshakes between the sequencer
// (master) and the memory / decode side (slave).
interface ip_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_addr,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_addr,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/ip_sequencer.sv
// Fetch/issue sequencer driving an external IP register through load and
// increment strobes; handles redirects, interrupt entry and halt.
module ip_sequencer
  import ip_sequencer_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         start_addr,
  input  logic [31:0]         ip,
  output logic                ip_ld,
  output logic                ip_inc,
  output logic [31:0]         ip_din,
  input  logic                redirect,
  input  logic [31:0]         redirect_addr,
  input  logic                irq,
  output logic [31:0]         epc,
  input  logic                halt,
  output logic                busy,
  ip_sequencer_if.master      bus
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pending_r;
  logic [31:0] instr_r;
  logic [31:0] instr_addr_r;
  logic [31:0] epc_r;
  logic        ld_s;
  logic        inc_s;
  logic [31:0] din_s;
  logic        capture_s;
  logic        pend_ld_s;
  logic        epc_ld_s;

  // Next-state decode and IP strobe generation.
  always_comb begin
    state_nxt_s = state_r;
    ld_s        = 1'b0;
    inc_s       = 1'b0;
    din_s       = 32'd0;
    capture_s   = 1'b0;
    pend_ld_s   = 1'b0;
    epc_ld_s    = 1'b0;
    if (reset) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            ld_s        = 1'b1;
            din_s       = start_addr;
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_REQ: begin
          if (redirect && bus.mem_ack) begin
            ld_s        = 1'b1;
            din_s       = redirect_addr;
            state_nxt_s = ST_REQ;
          end else if (redirect) begin
            pend_ld_s   = 1'b1;
            state_nxt_s = ST_DRAIN;
          end else if (bus.mem_ack) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_DRAIN: begin
          // A redirect arriving together with the ack is the newest target.
          if (bus.mem_ack) begin
            ld_s        = 1'b1;
            din_s       = redirect ? redirect_addr : pending_r;
            state_nxt_s = ST_REQ;
          end else if (redirect) begin
            pend_ld_s   = 1'b1;
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          if (redirect) begin
            ld_s        = 1'b1;
            din_s       = redirect_addr;
            state_nxt_s = ST_REQ;
          end else if (bus.instr_ready) begin
            if (irq) begin
              ld_s        = 1'b1;
              din_s       = IRQ_VECTOR;
              epc_ld_s    = 1'b1;
              state_nxt_s = ST_REQ;
            end else if (halt) begin
              inc_s       = 1'b1;
              state_nxt_s = ST_HALT;
            end else begin
              inc_s       = 1'b1;
              state_nxt_s = ST_REQ;
            end
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, captured instruction, pending redirect and EPC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pending_r    <= 32'd0;
      instr_r      <= 32'd0;
      instr_addr_r <= 32'd0;
      epc_r        <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (pend_ld_s) begin
        pending_r <= redirect_addr;
      end
      if (capture_s) begin
        instr_r      <= bus.mem_rdata;
        instr_addr_r <= ip;
      end
      if (epc_ld_s) begin
        epc_r <= ip_plus_one(ip);
      end
    end
  end

  assign ip_ld           = ld_s;
  assign ip_inc          = inc_s;
  assign ip_din          = din_s;
  assign epc             = epc_r;
  assign busy            = (state_r != ST_IDLE) && (state_r != ST_HALT);
  assign bus.mem_req     = (state_r == ST_REQ) || (state_r == ST_DRAIN);
  // ip is frozen while a fetch is outstanding, so the address stays stable.
  assign bus.mem_addr    = bus.mem_req ? ip : 32'd0;
  assign bus.instr_valid = (state_r == ST_ISSUE);
  assign bus.instr       = instr_r;
  assign bus.instr_addr  = instr_addr_r;

endmodule

// File: tb/tb_ip_sequencer.sv
// Bench for ip_sequencer: directed scenarios then random traffic, checked by
// a transaction-level scoreboard of expected issue addresses.
module tb_ip_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, redirect, irq, halt;
  logic [31:0] start_addr, redirect_addr, ip_q, ip_din, epc;
  logic        ip_ld, ip_inc, busy;

  ip_sequencer_if bus_if ();

  ip_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .ip(ip_q), .ip_ld(ip_ld), .ip_inc(ip_inc), .ip_din(ip_din),
    .redirect(redirect), .redirect_addr(redirect_addr), .irq(irq),
    .epc(epc), .halt(halt), .busy(busy), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // External IP register fed back to the sequencer.
  always @(posedge clk) begin
    if (reset)       ip_q <= 32'd0;
    else if (ip_ld)  ip_q <= ip_din;
    else if (ip_inc) ip_q <= ip_q + 32'd1;
  end

  int          n_tests = 0, n_fail = 0, inc_seen = 0, exp_inc = 0;
  logic        running = 1'b0;
  logic [31:0] exp_epc = 32'd0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  int          fixed_lat = 2;
  logic        late_ack = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Memory responder: ack after a latency counted from the start of each request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (late_ack) begin
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
      end else if (bus_if.mem_req) begin
        if (wait_cnt <= 0) begin
          bus_if.mem_ack   = 1'b1;
          bus_if.mem_rdata = memf(bus_if.mem_addr);
          wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else begin
          bus_if.mem_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'd0;
        wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor and reference model: the next issued address is the most recent
  // of start target, redirect target or successor of the accepted instruction.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        running = 1'b0;
        exp_epc = 32'd0;
      end else begin
        check1("ld_inc_exclusive", ip_ld & ip_inc, 1'b0);
        check1("busy", busy, running);
        check("epc", epc, exp_epc);
        if (bus_if.mem_req) check("mem_addr_vs_ip", bus_if.mem_addr, ip_q);
        if (ip_inc) inc_seen++;
        if (bus_if.instr_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got addr %h expected no issue", bus_if.instr_addr);
          end else begin
            check("instr_addr", bus_if.instr_addr, exp_q[0]);
            check("instr", bus_if.instr, memf(exp_q[0]));
          end
        end
        if (!running) begin
          if (start) begin
            running = 1'b1;
            exp_q.delete();
            exp_q.push_back(start_addr);
          end
        end else if (redirect) begin
          exp_q.delete();
          exp_q.push_back(redirect_addr);
        end else if (bus_if.instr_valid && bus_if.instr_ready && exp_q.size() != 0) begin
          a = exp_q.pop_front();
          acc_log.push_back(a);
          if (irq) begin
            exp_q.push_back(32'h0000_0100);
            exp_epc = a + 32'd1;
          end else if (halt) begin
            running = 1'b0;
            exp_inc++;
          end else begin
            exp_q.push_back(a + 32'd1);
            exp_inc++;
          end
        end
      end
    end
  end

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus_if.instr_valid && k < 60) begin
      cyc();
      k++;
    end
    if (!bus_if.instr_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout got no instr_valid expected instr_valid", name);
    end
  endtask

  task automatic stop_run(input string name);
    int k;
    k = 0;
    halt = 1'b1;
    redirect = 1'b0;
    irq = 1'b0;
    bus_if.instr_ready = 1'b1;
    while (running && k < 200) begin
      cyc();
      k++;
    end
    if (running) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout got running expected halted", name);
    end
    halt = 1'b0;
    cyc();
  endtask

  task automatic check_reset_vals(input string name);
    check1({name, "_ip_ld"}, ip_ld, 1'b0);
    check1({name, "_ip_inc"}, ip_inc, 1'b0);
    check1({name, "_mem_req"}, bus_if.mem_req, 1'b0);
    check1({name, "_instr_valid"}, bus_if.instr_valid, 1'b0);
    check1({name, "_busy"}, busy, 1'b0);
    check({name, "_ip_din"}, ip_din, 32'd0);
    check({name, "_mem_addr"}, bus_if.mem_addr, 32'd0);
    check({name, "_instr"}, bus_if.instr, 32'd0);
    check({name, "_instr_addr"}, bus_if.instr_addr, 32'd0);
    check({name, "_epc"}, epc, 32'd0);
  endtask

  task automatic pulse_start(input logic [31:0] addr);
    start = 1'b1;
    start_addr = addr;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; redirect = 1'b0; irq = 1'b0; halt = 1'b0;
    start_addr = 32'd0; redirect_addr = 32'd0; bus_if.instr_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check_reset_vals("reset");

    // Sequential fetch from 0x40 with two-cycle memory latency.
    fixed_lat = 2;
    bus_if.instr_ready = 1'b1;
    acc_log.delete();
    pulse_start(32'h40);
    k = 0;
    while (acc_log.size() < 3 && k < 60) begin cyc(); k++; end
    if (acc_log.size() < 3) begin
      n_tests++; n_fail++;
      $display("FAIL seq_fetch: got %0d issues expected 3", acc_log.size());
    end else begin
      check("seq_fetch0", acc_log[0], 32'h40);
      check("seq_fetch1", acc_log[1], 32'h41);
      check("seq_fetch2", acc_log[2], 32'h42);
    end
    stop_run("seq_halt");

    // Stall in ISSUE, then redirect one cycle before the ack.
    bus_if.instr_ready = 1'b0;
    pulse_start(32'h80);
    wait_valid("stall_issue");
    for (int i = 0; i < 3; i++) begin
      cyc();
      check1("stall_valid", bus_if.instr_valid, 1'b1);
      check1("stall_no_req", bus_if.mem_req, 1'b0);
      check1("stall_no_inc", ip_inc, 1'b0);
    end
    bus_if.instr_ready = 1'b1;
    cyc();
    bus_if.instr_ready = 1'b0;
    check1("drain_req1", bus_if.mem_req, 1'b1);
    cyc();
    redirect = 1'b1;
    redirect_addr = 32'h200;
    cyc();
    redirect = 1'b0;
    check1("drain_req_held", bus_if.mem_req, 1'b1);
    check("drain_addr_held", bus_if.mem_addr, 32'h81);
    check1("drain_no_valid", bus_if.instr_valid, 1'b0);
    cyc();
    check1("drain_refetch_req", bus_if.mem_req, 1'b1);
    check("drain_refetch_addr", bus_if.mem_addr, 32'h200);
    bus_if.instr_ready = 1'b1;
    wait_valid("drain_issue");
    check("drain_issue_addr", bus_if.instr_addr, 32'h200);
    stop_run("drain_halt");

    // Redirect beats irq; then irq alone at ip 0x10.
    bus_if.instr_ready = 1'b0;
    pulse_start(32'h10);
    wait_valid("irq_issue1");
    bus_if.instr_ready = 1'b1; irq = 1'b1; redirect = 1'b1; redirect_addr = 32'h10;
    #1;
    check1("redir_wins_ld", ip_ld, 1'b1);
    check("redir_wins_din", ip_din, 32'h10);
    cyc();
    bus_if.instr_ready = 1'b0; irq = 1'b0; redirect = 1'b0;
    check("redir_epc_unchanged", epc, 32'd0);
    wait_valid("irq_issue2");
    bus_if.instr_ready = 1'b1; irq = 1'b1;
    #1;
    check1("irq_ld", ip_ld, 1'b1);
    check("irq_din", ip_din, 32'h100);
    cyc();
    irq = 1'b0; bus_if.instr_ready = 1'b0;
    check("irq_epc", epc, 32'h11);
    stop_run("irq_halt");

    // Issue at the top of the address space, halt, then restart.
    halt = 1'b1; bus_if.instr_ready = 1'b1;
    pulse_start(32'hFFFF_FFFF);
    wait_valid("wrap_issue");
    #1;
    check1("wrap_inc", ip_inc, 1'b1);
    cyc();
    halt = 1'b0;
    check1("wrap_halted_busy", busy, 1'b0);
    check("wrap_ip", ip_q, 32'd0);
    pulse_start(32'h500);
    wait_valid("restart_issue");
    check("restart_addr", bus_if.instr_addr, 32'h500);

    // Reset while a fetch is outstanding; a late ack must be ignored.
    fixed_lat = 3;
    cyc();
    check1("rst_mid_req", bus_if.mem_req, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    late_ack = 1'b1;
    cyc();
    late_ack = 1'b0;
    cyc();
    check1("late_ack_busy", busy, 1'b0);
    check1("late_ack_req", bus_if.mem_req, 1'b0);
    check1("late_ack_valid", bus_if.instr_valid, 1'b0);

    // Random traffic.
    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      bus_if.instr_ready = ($urandom_range(0, 3) != 0);
      redirect = running && ($urandom_range(0, 15) == 0);
      redirect_addr = $urandom;
      irq = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 15) == 0);
      start = running ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 1) == 1);
      start_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      cyc();
    end
    start = 1'b0;
    stop_run("random_halt");
    check("inc_count", inc_seen, exp_inc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_sequencer.md
IP_SEQUENCER -- requirements
Module: ip_sequencer

Interface
REQ-001 Parameter IRQ_VECTOR, default 32'h0000_0100: address loaded into the IP on interrupt entry.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  pulse; begin fetching at start_addr (honoured in IDLE/HALT only).
REQ-005 start_addr  in  32  initial fetch address.
REQ-006 ip  in  32  current IP register value.
REQ-007 ip_ld / ip_inc  out  1 each  load/increment strobes to the IP register; never both high.
REQ-008 ip_din  out  32  IP load value, meaningful only when ip_ld=1.
REQ-009 mem_req  out  1 / mem_addr  out  32 / mem_ack  in  1 / mem_rdata  in  32  instruction memory handshake.
REQ-010 instr_valid  out  1 / instr  out  32 / instr_addr  out  32 / instr_ready  in  1  instruction issue handshake.
REQ-011 redirect  in  1 / redirect_addr  in  32  branch/jump redirect request.
REQ-012 irq  in  1  level interrupt request; epc  out  32  return address captured on interrupt entry.
REQ-013 halt  in  1  stop fetching after the current issue; busy  out  1  high in any state except IDLE/HALT.

Function
REQ-014 FSM states IDLE, REQ, ISSUE, DRAIN, HALT; reset state IDLE.
REQ-015 IDLE/HALT + start: ip_ld=1, ip_din=start_addr, next REQ; start ignored elsewhere.
REQ-016 REQ: mem_req=1, mem_addr=ip; mem_req and mem_addr held stable until mem_ack=1.
REQ-017 REQ + mem_ack, no pending redirect: instr<=mem_rdata, instr_addr<=ip, next ISSUE (min fetch-to-issue latency 1 cycle after ack).
REQ-018 ISSUE: instr_valid=1, instr/instr_addr stable until instr_ready=1.
REQ-019 ISSUE + instr_ready, priority redirect > irq > halt > normal.
REQ-020 Normal: ip_inc=1, next REQ.
REQ-021 irq: ip_ld=1, ip_din=IRQ_VECTOR, epc<=ip+1 (mod 2^32), next REQ.
REQ-022 halt: ip_inc=1, next HALT.
REQ-023 redirect in ISSUE (with or without instr_ready): ip_ld=1, ip_din=redirect_addr, instruction dropped (instr_valid low next cycle), next REQ.
REQ-024 redirect in REQ without mem_ack: redirect_addr latched into a pending register, next DRAIN; mem_req stays high.
REQ-025 redirect in REQ coinciding with mem_ack: data discarded, ip_ld with redirect_addr, next REQ.
REQ-026 DRAIN: mem_req=1 held; on mem_ack data discarded, ip_ld with pending address, next REQ; a later redirect in DRAIN overwrites the pending address.
REQ-027 irq and halt are sampled only per REQ-019; irq held while halted is not taken.
REQ-028 ip+1 wraps 32'hFFFF_FFFF -> 0; the increment itself is performed by the IP register.

Reset
REQ-029 reset overrides all inputs, including mid-handshake; outstanding mem_ack ignored.
REQ-030 Reset values: state IDLE, ip_ld=ip_inc=mem_req=instr_valid=busy=0, ip_din=mem_addr=instr=instr_addr=epc=0, pending register cleared.

Structure
REQ-031 Shared package holds the FSM state enumeration and the IRQ_VECTOR default.
REQ-032 No sub-modules; the IP register is instantiated alongside this block by the parent, ip fed back as input.

Verification
REQ-033 start_addr=0x40, mem_ack 2 cycles after each req, instr_ready=1 -> fetches 0x40,0x41,0x42; one ip_inc per issue.
REQ-034 instr_ready low 3 cycles in ISSUE -> instr/instr_addr stable, no ip_inc, no new mem_req.
REQ-035 redirect to 0x200 in REQ 1 cycle before mem_ack -> DRAIN, data discarded, next mem_addr=0x200.
REQ-036 irq and redirect same cycle as instr_ready at ip=0x10 -> redirect wins, epc unchanged; irq alone -> ip_din=0x100, epc=0x11.
REQ-037 ip=0xFFFF_FFFF issue then halt -> ip_inc, state HALT, busy=0; start restarts.
REQ-038 reset asserted while mem_req pending -> all outputs at reset values next cycle, late mem_ack ignored.
